// File: rtl/gpio_responder.sv
// Memory-mapped GPIO responder for the rv32i data port: LEDs, 4-digit 7-seg scan,
// synchronized switches and debounced buttons with sticky rising-edge capture.
module gpio_responder #(
  parameter int DEB_CYCLES     = 1000000,
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sel_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] write_i,
  input  logic        we_i,
  output logic [31:0] read_o,
  output logic [15:0] led_o,
  output logic [6:0]  seg_o,
  output logic [3:0]  an_o,
  input  logic [15:0] sw_i,
  input  logic        b0_i,
  input  logic        b1_i,
  input  logic        b2_i,
  input  logic        b3_i
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST     = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [31:0]   ID_VALUE     = 32'h6A10_0001;

  localparam logic [3:0] A_LED     = 4'd0;
  localparam logic [3:0] A_SEGVAL  = 4'd1;
  localparam logic [3:0] A_SEGCTRL = 4'd2;
  localparam logic [3:0] A_SW      = 4'd3;
  localparam logic [3:0] A_BTNLVL  = 4'd4;
  localparam logic [3:0] A_BTNEDGE = 4'd5;
  localparam logic [3:0] A_ID      = 4'd6;

  logic [15:0]   led_q, segval_q;
  logic [3:0]    segctrl_q, btnedge_q;
  logic [15:0]   sw_s1, sw_s2;
  logic [3:0]    btn_raw, btn_s1, btn_s2, btn_stable;
  logic [DW-1:0] deb_cnt [4];
  logic [3:0]    deb_done, btn_rise, edge_clr;
  logic [RW-1:0] scan_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    digit_val;
  logic          wr_en;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign btn_raw   = {b3_i, b2_i, b1_i, b0_i};
  assign wr_en     = sel_i & we_i;
  assign led_o     = led_q;
  assign digit_val = segval_q[{digit_idx, 2'b00} +: 4];

  // A button qualifies on the edge its count expires; a rise is that edge with sync=1.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    deb_done = '0;
    for (int k = 0; k < 4; k++)
      deb_done[k] = (btn_s2[k] != btn_stable[k]) && (deb_cnt[k] == DEB_LAST);
    btn_rise = deb_done & btn_s2;
    edge_clr = (wr_en && addr_i == A_BTNEDGE) ? write_i[3:0] : 4'h0;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    if (!rst_i) begin
      led_q     <= '0;
      segval_q  <= '0;
      segctrl_q <= 4'hF;
      btnedge_q <= '0;
    end else begin
      if (wr_en) begin
        case (addr_i)
          A_LED:     led_q     <= write_i[15:0];
          A_SEGVAL:  segval_q  <= write_i[15:0];
          A_SEGCTRL: segctrl_q <= write_i[3:0];
          default:   ;
        endcase
      end
      // Set has priority over a write-1-to-clear on the same bit.
      btnedge_q <= (btnedge_q & ~edge_clr) | btn_rise;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sw_s1      <= '0;
      sw_s2      <= '0;
      btn_s1     <= '0;
      btn_s2     <= '0;
      btn_stable <= '0;
      for (int k = 0; k < 4; k++) deb_cnt[k] <= '0;
    end else begin
      sw_s1  <= sw_i;
      sw_s2  <= sw_s1;
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      for (int k = 0; k < 4; k++) begin
        if (btn_s2[k] == btn_stable[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_done[k]) begin
          deb_cnt[k]    <= '0;
          btn_stable[k] <= btn_s2[k];
        end else begin
          deb_cnt[k] <= deb_cnt[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      an_o      <= 4'hF;
      seg_o     <= 7'h7F;
    end else begin
      if (scan_cnt == REFRESH_LAST) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (segctrl_q[digit_idx]) begin
        an_o  <= ~(4'b0001 << digit_idx);
        seg_o <= hex7(digit_val);
      end else begin
        an_o  <= 4'hF;
        seg_o <= 7'h7F;
      end
    end
  end

  always_comb begin
    read_o = '0;
    if (sel_i) begin
      case (addr_i)
        A_LED:     read_o = {16'h0, led_q};
        A_SEGVAL:  read_o = {16'h0, segval_q};
        A_SEGCTRL: read_o = {28'h0, segctrl_q};
        A_SW:      read_o = {16'h0, sw_s2};
        A_BTNLVL:  read_o = {28'h0, btn_stable};
        A_BTNEDGE: read_o = {28'h0, btnedge_q};
        A_ID:      read_o = ID_VALUE;
        default:   read_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_responder.sv
// Self-checking bench for gpio_responder with short debounce/refresh periods:
// a register-access vector table plus scan, debounce, edge and reset sequences.
module tb_gpio_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic [15:0] led;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] sw;
  logic [3:0]  btn;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        sel;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_read;
    logic [15:0] exp_led;
  } vec_t;
  vec_t vecs [17];

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] an_tbl [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  gpio_responder #(.DEB_CYCLES(4), .REFRESH_CYCLES(8)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .sel_i   (sel),
    .addr_i  (addr),
    .write_i (wdata),
    .we_i    (we),
    .read_o  (rdata),
    .led_o   (led),
    .seg_o   (seg),
    .an_o    (an),
    .sw_i    (sw),
    .b0_i    (btn[0]),
    .b1_i    (btn[1]),
    .b2_i    (btn[2]),
    .b3_i    (btn[3])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check();
    exp_t e;
    e = sb_q.pop_front();
    check(e.name, rdata, e.val);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e, input string n);
    sel = 1'b1; we = 1'b0; addr = a;
    sb_push(n, e);
    #1;
    sb_pop_check();
    sel = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] target, input string n);
    int cnt;
    cnt = 0;
    while (an !== target && cnt < 64) begin
      tick();
      cnt++;
    end
    check(n, {28'h0, an}, {28'h0, target});
  endtask

  task automatic check_scan(input logic [3:0] ctrl, input string n);
    int k;
    for (int i = 0; i < 32; i++) begin
      k = i / 8;
      if (ctrl[k]) begin
        check($sformatf("%s_an_c%0d", n, i), {28'h0, an}, {28'h0, an_tbl[k]});
        check($sformatf("%s_seg_c%0d", n, i), {25'h0, seg}, {25'h0, hex_tbl[k]});
      end else begin
        check($sformatf("%s_an_c%0d", n, i), {28'h0, an}, 32'hF);
        check($sformatf("%s_seg_c%0d", n, i), {25'h0, seg}, 32'h7F);
      end
      tick();
    end
  endtask

  task automatic run_vectors();
    vecs[0]  = '{1'b1, 1'b0, 4'd2,  32'h0,        32'h0000_000F, 16'h0};
    vecs[1]  = '{1'b1, 1'b0, 4'd6,  32'h0,        32'h6A10_0001, 16'h0};
    vecs[2]  = '{1'b0, 1'b0, 4'd6,  32'h0,        32'h0,         16'h0};
    vecs[3]  = '{1'b1, 1'b0, 4'd0,  32'h0,        32'h0,         16'h0};
    vecs[4]  = '{1'b1, 1'b1, 4'd0,  32'hFFFF_A5A5, 32'h0,        16'hA5A5};
    vecs[5]  = '{1'b1, 1'b0, 4'd0,  32'h0,        32'h0000_A5A5, 16'hA5A5};
    vecs[6]  = '{1'b0, 1'b1, 4'd0,  32'h0000_1111, 32'h0,        16'hA5A5};
    vecs[7]  = '{1'b1, 1'b0, 4'd0,  32'h0,        32'h0000_A5A5, 16'hA5A5};
    vecs[8]  = '{1'b0, 1'b1, 4'd3,  32'h0000_FFFF, 32'h0,        16'hA5A5};
    vecs[9]  = '{1'b1, 1'b1, 4'd3,  32'h0000_FFFF, 32'h0000_1234, 16'hA5A5};
    vecs[10] = '{1'b1, 1'b0, 4'd3,  32'h0,        32'h0000_1234, 16'hA5A5};
    vecs[11] = '{1'b1, 1'b0, 4'd7,  32'h0,        32'h0,         16'hA5A5};
    vecs[12] = '{1'b1, 1'b0, 4'd4,  32'h0,        32'h0,         16'hA5A5};
    vecs[13] = '{1'b1, 1'b0, 4'd5,  32'h0,        32'h0,         16'hA5A5};
    vecs[14] = '{1'b1, 1'b1, 4'd2,  32'hFFFF_FFF0, 32'h0000_000F, 16'hA5A5};
    vecs[15] = '{1'b1, 1'b1, 4'd2,  32'h0000_000F, 32'h0,        16'hA5A5};
    vecs[16] = '{1'b1, 1'b0, 4'd15, 32'h0,        32'h0,         16'hA5A5};
    for (int i = 0; i < 17; i++) begin
      sel = vecs[i].sel; we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
      sb_push($sformatf("vec%0d_read", i), vecs[i].exp_read);
      #1;
      sb_pop_check();
      tick();
      check($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
    end
    sel = 1'b0; we = 1'b0;
    rd(4'd2, 32'hF, "segctrl_restored");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    sw = 16'h1234; btn = 4'h0;
    repeat (3) tick();
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_an", {28'h0, an}, 32'hF);
    check("rst_seg", {25'h0, seg}, 32'h7F);
    rst = 1'b1;

    run_vectors();

    // Scan with all digits enabled, then with digits 1 and 3 blanked.
    wr(4'd1, 32'h0000_3210);
    wait_an(4'hB, "align_b");
    wait_an(4'hE, "align_e");
    check_scan(4'hF, "scan_all");
    wr(4'd2, 32'h0000_0005);
    wait_an(4'hB, "align2_b");
    wait_an(4'hE, "align2_e");
    check_scan(4'h5, "scan_mask");

    // b0 bounces with a 2-cycle half period; the level must never qualify.
    for (int p = 0; p < 6; p++) begin
      btn[0] = (p % 2 == 0);
      repeat (2) begin
        tick();
        rd(4'd4, 32'h0, $sformatf("bounce_lvl_p%0d", p));
      end
    end
    btn[0] = 1'b1;
    repeat (5) tick();
    rd(4'd4, 32'h0, "deb_lvl_edge5");
    tick();
    rd(4'd4, 32'h1, "deb_lvl_edge6");
    rd(4'd5, 32'h1, "deb_edge_set");

    wr(4'd5, 32'h1);
    rd(4'd5, 32'h0, "edge_w1c");
    rd(4'd4, 32'h1, "lvl_after_w1c");

    // Clear both bits on the very edge b1 qualifies: b1 set must survive.
    btn[1] = 1'b1;
    repeat (5) tick();
    rd(4'd4, 32'h1, "b1_lvl_pending");
    sel = 1'b1; we = 1'b1; addr = 4'd5; wdata = 32'h3;
    tick();
    sel = 1'b0; we = 1'b0;
    rd(4'd5, 32'h2, "edge_set_wins");
    rd(4'd4, 32'h3, "lvl_b0_b1");

    // Reset in the middle of a b2 debounce while digit 2 is on.
    wait_an(4'hB, "mid_align_b");
    btn[2] = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    check("midrst_an", {28'h0, an}, 32'hF);
    check("midrst_led", {16'h0, led}, 32'h0);
    rst = 1'b1;
    tick();
    check("post_rst_an_c1", {28'h0, an}, 32'hE);
    rd(4'd4, 32'h0, "post_rst_lvl");
    rd(4'd5, 32'h0, "post_rst_edge");
    for (int i = 2; i <= 8; i++) begin
      tick();
      check($sformatf("post_rst_an_c%0d", i), {28'h0, an}, 32'hE);
      if (i == 5) rd(4'd4, 32'h0, "post_rst_lvl_c5");
      if (i == 6) rd(4'd4, 32'h7, "post_rst_lvl_c6");
    end
    tick();
    check("post_rst_an_c9", {28'h0, an}, 32'hD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
